// File: rtl/i2c_master_burst.sv
// rtl/i2c_master_burst.sv - burst I2C master: START, address, 0..N data bytes, STOP per command
module i2c_master_burst #(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 7,
    parameter int LEN_WD  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               r_w,
    input  logic [ADDR_WD-1:0] addr,
    input  logic [LEN_WD-1:0]  len,
    input  logic [DATA_WD-1:0] wdata,
    output logic               wr_ready,
    output logic [DATA_WD-1:0] rdata,
    output logic               rdata_valid,
    output logic               busy,
    output logic               done,
    output logic               nack,
    output logic               scl,
    output logic               sda_oe,
    input  logic               sda_i
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(ADDR_WD + DATA_WD + 2);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP
    } state_t;

    state_t             state;
    logic [QW-1:0]      qdiv;
    logic [1:0]         quarter;
    logic [BW-1:0]      bit_cnt;
    logic [LEN_WD-1:0]  byte_cnt;
    logic               rw_q;
    logic               ack_n;
    logic [ADDR_WD:0]   frame;
    logic [DATA_WD-1:0] wsh;
    logic [DATA_WD-1:0] rsh;
    logic               q_end;
    logic               sample_now;

    // Quarter boundary and the SDA sampling point (first clk of Q3)
    always_comb begin
        q_end      = (qdiv == QW'(CLK_DIV - 1));
        sample_now = (qdiv == '0) && (quarter == 2'd3);
    end

    // Command sequencer: slot timing, line drive, byte shifting and handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            qdiv        <= '0;
            quarter     <= 2'd0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            rw_q        <= 1'b0;
            ack_n       <= 1'b0;
            frame       <= '0;
            wsh         <= '0;
            rsh         <= '0;
            scl         <= 1'b1;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            nack        <= 1'b0;
            wr_ready    <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
        end else begin
            wr_ready    <= 1'b0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            if (state == IDLE) begin
                // a start coinciding with the done pulse is dropped
                if (start && !done) begin
                    state    <= START;
                    busy     <= 1'b1;
                    frame    <= {addr, r_w};
                    rw_q     <= r_w;
                    byte_cnt <= len;
                    nack     <= 1'b0;
                    qdiv     <= '0;
                    quarter  <= 2'd0;
                    scl      <= 1'b1;
                    sda_oe   <= 1'b1;
                end
            end else begin
                if (sample_now) begin
                    ack_n <= sda_i;
                    if (state == READ)
                        rsh <= {rsh[DATA_WD-2:0], sda_i};
                end
                // wdata arrives in the wr_ready cycle, so the first bit goes out one clk into Q0
                if (state == WRITE && qdiv == '0 && quarter == 2'd0 && bit_cnt == '0) begin
                    sda_oe <= ~wdata[DATA_WD-1];
                    wsh    <= {wdata[DATA_WD-2:0], 1'b0};
                end
                if (q_end) begin
                    qdiv    <= '0;
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd0 && state == STOP)
                        scl <= 1'b1;
                    if (quarter == 2'd1) begin
                        if (state == START)
                            scl <= 1'b0;
                        else if (state == STOP)
                            sda_oe <= 1'b0;
                        else
                            scl <= 1'b1;
                    end
                    if (quarter == 2'd3) begin
                        scl <= 1'b0;
                        case (state)
                            START: begin
                                state   <= ADDR;
                                bit_cnt <= '0;
                                sda_oe  <= ~frame[ADDR_WD];
                                frame   <= {frame[ADDR_WD-1:0], 1'b0};
                            end
                            ADDR: begin
                                if (bit_cnt == BW'(ADDR_WD)) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    sda_oe  <= ~frame[ADDR_WD];
                                    frame   <= {frame[ADDR_WD-1:0], 1'b0};
                                end
                            end
                            ADDR_ACK: begin
                                bit_cnt <= '0;
                                if (ack_n || byte_cnt == '0) begin
                                    nack   <= nack | ack_n;
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else if (rw_q) begin
                                    state <= READ;
                                end else begin
                                    state    <= WRITE;
                                    wr_ready <= 1'b1;
                                end
                            end
                            WRITE: begin
                                if (bit_cnt == BW'(DATA_WD - 1)) begin
                                    state  <= WR_ACK;
                                    sda_oe <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    sda_oe  <= ~wsh[DATA_WD-1];
                                    wsh     <= {wsh[DATA_WD-2:0], 1'b0};
                                end
                            end
                            WR_ACK: begin
                                bit_cnt <= '0;
                                if (ack_n || byte_cnt == LEN_WD'(1)) begin
                                    nack   <= nack | ack_n;
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state    <= WRITE;
                                    wr_ready <= 1'b1;
                                end
                                if (!ack_n)
                                    byte_cnt <= byte_cnt - 1'b1;
                            end
                            READ: begin
                                if (bit_cnt == BW'(DATA_WD - 1)) begin
                                    state       <= RD_ACK;
                                    rdata       <= rsh;
                                    rdata_valid <= 1'b1;
                                    // ACK every byte but the last one
                                    sda_oe      <= (byte_cnt != LEN_WD'(1));
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            RD_ACK: begin
                                bit_cnt  <= '0;
                                byte_cnt <= byte_cnt - 1'b1;
                                if (byte_cnt == LEN_WD'(1)) begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state  <= READ;
                                    sda_oe <= 1'b0;
                                end
                            end
                            STOP: begin
                                scl   <= 1'b1;
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end else begin
                    qdiv <= qdiv + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_burst.sv
// tb/tb_i2c_master_burst.sv - scoreboard bench for i2c_master_burst with behavioural I2C slave
module tb_i2c_master_burst;
    localparam int DATA_WD = 8;
    localparam int ADDR_WD = 7;
    localparam int LEN_WD  = 4;
    localparam int CLK_DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         r_w = 1'b0;
    logic [6:0]   addr = '0;
    logic [3:0]   len = '0;
    logic [7:0]   wdata = '0;
    logic         wr_ready, rdata_valid, busy, done, nack, scl, sda_oe, sda_i;
    logic [7:0]   rdata;
    logic         slave_pull = 1'b0;

    assign sda_i = ~sda_oe & ~slave_pull;

    always #5 clk = ~clk;

    i2c_master_burst #(
        .DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD), .LEN_WD(LEN_WD), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .r_w(r_w), .addr(addr), .len(len),
        .wdata(wdata), .wr_ready(wr_ready), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .done(done), .nack(nack), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int lat;
        bit nk;
        int wrc;
    } exp_t;

    exp_t       exp_done[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_rdata[$];
    bit         exp_mack[$];

    logic [7:0] wbuf[16];
    logic [7:0] rbuf[16];
    int         widx = 0;
    bit         wr_seen = 0;

    bit nack_addr = 0;
    int nack_at = 0;
    int slv_len = 0;
    bit slave_rst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write data feed: advance after the DUT has sampled wdata in the wr_ready cycle
    always @(negedge clk) wr_seen = wr_ready;
    always @(posedge clk) begin
        if (wr_seen) begin
            #1;
            if (widx < 15) widx++;
            wdata = wbuf[widx];
        end
    end

    // behavioural slave: decodes START/STOP and bits from SCL/SDA edges
    bit         prev_scl = 1, prev_sda = 1, active = 0, rd_mode = 0, rd_stop = 0;
    int         bitn = 0, byte_idx = 0;
    logic [7:0] shift = '0;
    always @(negedge clk) begin
        if (slave_rst) begin
            active = 0; slave_pull = 0; prev_scl = 1; prev_sda = 1;
        end else begin
            if (scl && prev_scl && prev_sda && !sda_i) begin
                active = 1; bitn = 0; byte_idx = 0; rd_mode = 0; rd_stop = 0; shift = '0;
            end else if (scl && prev_scl && !prev_sda && sda_i) begin
                active = 0; slave_pull = 0;
            end else if (active && scl && !prev_scl) begin
                if (bitn < 8) begin
                    shift = {shift[6:0], sda_i};
                    bitn++;
                    if (bitn == 8) begin
                        if (byte_idx == 0) rd_mode = shift[0];
                        if (byte_idx == 0 || !rd_mode) begin
                            if (exp_bytes.size() == 0) begin
                                checks++; failures++;
                                $display("FAIL sda_byte: got %0h expected none", shift);
                            end else begin
                                check("sda_byte", shift, exp_bytes.pop_front());
                            end
                        end
                    end
                end else begin
                    if (rd_mode && byte_idx > 0) begin
                        if (exp_mack.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL master_ack: got %0b expected none", sda_i);
                        end else begin
                            check("master_ack", sda_i, exp_mack.pop_front());
                        end
                        if (sda_i) rd_stop = 1;
                    end
                    if (byte_idx == 0 && nack_addr) active = 0;
                    if (!rd_mode && byte_idx > 0 && byte_idx == nack_at) active = 0;
                    bitn = 0;
                    byte_idx++;
                end
            end else if (active && !scl && prev_scl) begin
                if (bitn == 8 && (byte_idx == 0 || !rd_mode))
                    slave_pull = ~(byte_idx == 0 ? nack_addr : (byte_idx == nack_at));
                else if (bitn < 8 && rd_mode && byte_idx > 0 && byte_idx <= slv_len && !rd_stop)
                    slave_pull = ~rbuf[byte_idx-1][7-bitn];
                else
                    slave_pull = 0;
            end
            prev_scl = scl;
            prev_sda = sda_i;
        end
    end

    // output monitor: latency from busy rise, wr_ready count, rdata and done results
    bit busy_d = 0;
    int lat = 0, wrc = 0;
    always @(negedge clk) begin
        if (busy && !busy_d) begin
            lat = 0; wrc = 0;
        end else begin
            lat++;
        end
        if (wr_ready) wrc++;
        if (rdata_valid) begin
            if (exp_rdata.size() == 0) begin
                checks++; failures++;
                $display("FAIL rdata: got %0h expected none", rdata);
            end else begin
                check("rdata", rdata, exp_rdata.pop_front());
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                checks++; failures++;
                $display("FAIL done: got unexpected pulse expected none");
            end else begin
                exp_t e;
                e = exp_done.pop_front();
                check("done_latency", lat, e.lat);
                check("nack", nack, e.nk);
                check("wr_ready_count", wrc, e.wrc);
                check("busy_at_done", busy, 0);
            end
        end
        busy_d = busy;
    end

    task automatic run_cmd(input bit rw, input logic [6:0] a, input int ln,
                           input bit na, input int nat, input bit collide);
        int n;
        bit nk;
        exp_t e;
        nk = na || (!rw && nat > 0 && nat <= ln);
        n  = na ? 0 : ((!rw && nat > 0 && nat <= ln) ? nat : ln);
        e.lat = 4 * CLK_DIV * (1 + (ADDR_WD + 2) + n * (DATA_WD + 1) + 1);
        e.nk  = nk;
        e.wrc = rw ? 0 : n;
        exp_done.push_back(e);
        exp_bytes.push_back({a, rw});
        if (!rw)
            for (int i = 0; i < n; i++) exp_bytes.push_back(wbuf[i]);
        if (rw && !na)
            for (int i = 0; i < ln; i++) begin
                exp_rdata.push_back(rbuf[i]);
                exp_mack.push_back(i == ln - 1);
            end
        nack_addr = na;
        nack_at   = rw ? 0 : nat;
        slv_len   = ln;
        widx  = 0;
        wdata = wbuf[0];
        @(negedge clk);
        start = 1; r_w = rw; addr = a; len = 4'(ln);
        @(negedge clk);
        start = 0; r_w = ~rw; addr = 7'($urandom); len = 4'($urandom);
        if (collide) begin
            repeat (150) @(negedge clk);
            start = 1; addr = 7'h22; r_w = ~rw; len = 4'd5;
            @(negedge clk);
            start = 0;
        end
        for (int i = 0; i < 5000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen", done, 1);
        repeat (3) @(negedge clk);
        check("nack_hold", nack, nk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_cmd(0, 7'h50, 2, 0, 0, 0);
        run_cmd(0, 7'h11, 2, 1, 0, 0);
        rbuf[0] = 8'h12; rbuf[1] = 8'h34; rbuf[2] = 8'h56;
        run_cmd(1, 7'h50, 3, 0, 0, 0);
        run_cmd(0, 7'h50, 0, 0, 0, 0);
        wbuf[0] = 8'h5E; wbuf[1] = 8'hC3;
        run_cmd(0, 7'h50, 2, 0, 0, 1);
        wbuf[0] = 8'h81; wbuf[1] = 8'h7F; wbuf[2] = 8'h00;
        run_cmd(0, 7'h2B, 3, 0, 2, 0);

        // reset mid-transfer
        nack_addr = 0; nack_at = 0; slv_len = 2;
        exp_bytes.push_back({7'h3A, 1'b0});
        widx = 0; wdata = wbuf[0];
        @(negedge clk);
        start = 1; r_w = 0; addr = 7'h3A; len = 4'd2;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wr_ready) break;
            @(negedge clk);
        end
        check("abort_wr_ready_seen", wr_ready, 1);
        repeat (20) @(negedge clk);
        rst_n = 0; slave_rst = 1;
        @(negedge clk);
        check("abort_scl", scl, 1);
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", busy, 0);
        rst_n = 1;
        @(negedge clk);
        slave_rst = 0;
        exp_bytes.delete();
        repeat (2) @(negedge clk);
        wbuf[0] = 8'h96;
        run_cmd(0, 7'h3A, 1, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            bit rw, na;
            int ln, nat;
            logic [6:0] a;
            rw  = 1'($urandom);
            a   = 7'($urandom);
            ln  = $urandom_range(0, 4);
            na  = ($urandom % 5) == 0;
            nat = 0;
            if (!rw && ln > 0 && ($urandom % 3) == 0) nat = $urandom_range(1, ln);
            for (int i = 0; i < 16; i++) begin
                wbuf[i] = 8'($urandom);
                rbuf[i] = 8'($urandom);
            end
            run_cmd(rw, a, ln, na, nat, 0);
        end

        check("left_bytes", exp_bytes.size(), 0);
        check("left_rdata", exp_rdata.size(), 0);
        check("left_mack", exp_mack.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_master_burst.md
Name: i2c_master_burst

Overview:
- Parametrised I2C master that is the next generation of the single-byte I2C controller.
- Runs one START, address+R/W, 0..N data bytes, STOP sequence per command, with a programmable SCL divider.
- Detects slave NACK on the address byte and on written data bytes.
- Drives SDA open-drain style so it connects to the existing memory slave model or a real bus through a top-level pad.

Parameters:
- DATA_WD, 8, bits per data byte, sent MSB first.
- ADDR_WD, 7, slave address bits; the address frame is {addr, r_w}, ADDR_WD+1 bits.
- LEN_WD, 4, width of the burst length field; up to 2^LEN_WD-1 bytes.
- CLK_DIV, 4, clk cycles per SCL quarter-period (must be >= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- r_w  in  1  1 = read, 0 = write; latched on accepted start.
- addr  in  ADDR_WD  slave address; latched on accepted start.
- len  in  LEN_WD  byte count; latched on accepted start.
- wdata  in  DATA_WD  write byte; sampled in the wr_ready cycle.
- wr_ready  out  1  one-cycle pulse requesting and sampling the next wdata.
- rdata  out  DATA_WD  last received byte; held until the next read byte.
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command end.
- nack  out  1  slave NACK seen in this command; held until the next accepted start.
- scl  out  1  SCL level (push-pull; no clock stretching).
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_i  in  1  sampled SDA bus level.

Behaviour:
- Single clock domain. Reset is synchronous, active-low, clocked on clk.
- Reset values: scl=1, sda_oe=0, busy=0, done=0, nack=0, wr_ready=0, rdata_valid=0, rdata=0; FSM goes to IDLE.
- Reset mid-transfer aborts immediately and releases both lines on the next edge. No STOP is generated.
- Timing unit: the bit slot. Each slot is 4 quarters Q0..Q3 of CLK_DIV clk each, so 4*CLK_DIV clk per slot.
- Data/ack slot:
  - scl=0 in Q0 and Q1; scl=1 in Q2 and Q3.
  - sda_oe changes only at the Q0 entry.
  - sda_i is sampled on the first clk of Q3.
- FSM states: IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, STOP.
- IDLE:
  - start=1 latches r_w, addr and len, clears nack, and sets busy=1 on the next cycle.
  - start while busy=1 is ignored.
- START (1 slot): Q0-Q1 scl=1 with sda_oe=1 (START condition); Q2-Q3 scl=0 with sda_oe=1.
- ADDR (ADDR_WD+1 slots): shifts out {addr, r_w} MSB first. sda_oe = ~bit.
- ADDR_ACK (1 slot): sda_oe=0 and sample sda_i.
  - sda_i=1: set nack and go to STOP.
  - len=0: go to STOP (address probe).
  - Otherwise go to WRITE if r_w=0, or READ if r_w=1.
- WRITE (DATA_WD slots per byte): wr_ready pulses on the first clk of the byte's first Q0, and wdata is captured that same cycle.
- WR_ACK: sda_oe=0 and sample sda_i.
  - sda_i=1: set nack and go to STOP.
  - Else, if bytes remain, go to WRITE; otherwise go to STOP.
- READ: sda_oe=0 and shift sda_i in MSB first.
- RD_ACK:
  - rdata updates and rdata_valid pulses on the first clk of this slot.
  - Master drives ACK (sda_oe=1) for every byte except the last, which gets NACK (sda_oe=0). The master's NACK does not set nack.
- STOP (1 slot):
  - Q0: scl=0, sda_oe=1.
  - Q1: scl=1, sda_oe=1.
  - Q2-Q3: scl=1, sda_oe=0 (STOP condition).
- Completion: after STOP Q3 ends, done pulses for 1 cycle, busy falls in the same cycle, and the FSM returns to IDLE.
- Latency: done is asserted exactly 4*CLK_DIV*(1 + (ADDR_WD+2) + n*(DATA_WD+1) + 1) clk after busy rises. n = len, or the number of completed bytes up to and including the NACKed one.
- Byte counter is LEN_WD wide and counts down to zero with no wrap.
- start arriving in the same cycle as done is ignored; a new command can be accepted the cycle after done.

Test Plan:
- Write, defaults: addr=0x50, r_w=0, len=2, wdata 0xA5 then 0x3C, slave ACKs all → SDA bits 1010000_0, A5, 3C; two wr_ready pulses; done 464 clk after busy rises; nack=0.
- Address NACK: addr=0x11, no slave ACK → nack=1; STOP follows ADDR_ACK; zero wr_ready pulses; done 176 clk after busy rises.
- Read: addr=0x50, r_w=1, len=3, slave returns 0x12, 0x34, 0x56 → three rdata_valid pulses with those values; master SDA low at ACK slots 1-2 and released at slot 3; nack=0.
- Probe: len=0 with ACK → START, address, ACK, STOP; done at 176 clk; nack=0.
- Busy collision: start pulsed mid-transfer with different addr → ignored; original transfer completes unchanged.
- Reset mid-transfer: rst_n=0 for 1 cycle during WRITE → next cycle scl=1, sda_oe=0, busy=0; a new command completes normally afterwards.
